icache_dm: RTL and testbench

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_data_array.sv | 23 ++
 rtl/icache_dm.sv | 166 ++++++++++++++++
 tb/tb_icache_dm.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_FILL   = 2'd1,
    ST_BYPASS = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 32;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/icache_data_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
module icache_data_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; valid bits gate every read, so contents never need clearing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: blocking line fill, uncached bypass below BASE_ADDRESS.
// Hit/miss counter outputs exist only when ICACHE_STATS_EN is defined.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter logic [31:0] BASE_ADDRESS   = DEFAULT_BASE_ADDRESS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      cpu_instr,
  output logic             hold,
  input  logic             flush,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned AW    = IDX_W + OFF_W;
  localparam int unsigned TAG_W = 30 - AW;
  localparam int unsigned WC_W  = (OFF_W > 0) ? OFF_W : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_LINE - 1);
  localparam logic [31:0]     LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

  state_e            state, state_next;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [WC_W-1:0]   word_cnt;
  logic              pend_flush;

  logic [IDX_W-1:0]  cpu_idx, mem_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic              cacheable, hit;
  logic [31:0]       rd_data;
  logic              start_miss, fill_we, fill_last, byp_done;

  assign cpu_idx   = cpu_addr[2+OFF_W +: IDX_W];
  assign cpu_tag   = cpu_addr[31 -: TAG_W];
  assign mem_idx   = mem_addr[2+OFF_W +: IDX_W];
  assign cacheable = (cpu_addr >= BASE_ADDRESS);
  assign hit       = cacheable && valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);

  icache_data_array #(
    .DEPTH (LINES * WORDS_PER_LINE),
    .AW    (AW)
  ) u_data (
    .clk   (clk),
    .we    (fill_we),
    .waddr (mem_addr[2 +: AW]),
    .wdata (mem_rdata),
    .raddr (cpu_addr[2 +: AW]),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_LOOKUP;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    hold       = 1'b0;
    cpu_instr  = rd_data;
    start_miss = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    byp_done   = 1'b0;
    case (state)
      ST_LOOKUP: begin
        if (cpu_req && !hit) begin
          hold       = 1'b1;
          start_miss = 1'b1;
          state_next = cacheable ? ST_FILL : ST_BYPASS;
        end
      end
      ST_FILL: begin
        hold = 1'b1;
        if (mem_ack) begin
          fill_we = 1'b1;
          if (word_cnt == LAST_WORD) begin
            fill_last  = 1'b1;
            state_next = ST_LOOKUP;
          end
        end
      end
      ST_BYPASS: begin
        cpu_instr = mem_rdata;
        hold      = !mem_ack;
        if (mem_ack) begin
          byp_done   = 1'b1;
          state_next = ST_LOOKUP;
        end
      end
      default: state_next = ST_LOOKUP;
    endcase
  end

  // mem_addr doubles as the latched line base and the current fill word address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      word_cnt   <= '0;
      pend_flush <= 1'b0;
      valid      <= '0;
    end else begin
      if (start_miss) begin
        mem_req  <= 1'b1;
        word_cnt <= '0;
        mem_addr <= cacheable ? (cpu_addr & LINE_MASK) : cpu_addr;
      end else if (fill_we) begin
        if (fill_last) begin
          mem_req <= 1'b0;
        end else begin
          mem_addr <= mem_addr + 32'd4;
          word_cnt <= word_cnt + WC_W'(1);
        end
      end else if (byp_done) begin
        mem_req <= 1'b0;
      end

      if (fill_last || byp_done)                 pend_flush <= 1'b0;
      else if (state != ST_LOOKUP && flush)      pend_flush <= 1'b1;

      if (fill_last || byp_done) begin
        if (pend_flush || flush) valid <= '0;
        else if (fill_last)      valid[mem_idx] <= 1'b1;
      end else if (state == ST_LOOKUP) begin
        if (flush)                          valid <= '0;
        else if (start_miss && cacheable)   valid[cpu_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_miss && cacheable) tags[cpu_idx] <= cpu_tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == ST_LOOKUP && cpu_req && hit && hit_count != '1)
        hit_count <= hit_count + CNT_W'(1);
      if (start_miss && miss_count != '1)
        miss_count <= miss_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetch/flush traffic
// against a line-level cache model; counters are checked when ICACHE_STATS_EN is defined.
module tb_icache_dm;

  localparam int          LINES = 16;
  localparam int          WPL   = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          LINE_BYTES = WPL * 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_instr;
  logic        hold;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_dm #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL),
    .BASE_ADDRESS   (BASE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_instr  (cpu_instr),
    .hold       (hold),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: every word holds its own byte address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a;
  endfunction

  // ---------------- behavioural cache model ----------------
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic int m_index(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return (a >= BASE) && mvalid[m_index(a)] && (mtag[m_index(a)] == m_tagof(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  // ---------------- backing memory responder ----------------
  int lat_fixed = 2;   // 0 selects a random latency of 1..3 per word
  bit spur_en   = 1'b0;
  int lat_sum   = 0;

  initial begin
    int cnt = 0;
    int lat = 1;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) cnt = 0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (reset_n && mem_req) begin
        cnt++;
        if (cnt == 1) lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
        if (cnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          lat_sum  += lat;
        end
      end else begin
        cnt = 0;
        if (spur_en && $urandom_range(0, 5) == 0) mem_ack = 1'b1;
      end
    end
  end

  // Every cycle the CPU is released, it must be holding the right instruction.
  always @(negedge clk) begin
    if (reset_n && cpu_req && !hold) check("instr", cpu_instr, mem_fn(cpu_addr));
  end

  logic [31:0] ack_addrs [$];
  logic [31:0] last_instr;

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
  endtask

  // One CPU fetch, held until released; entered and left just after a rising edge.
  task automatic fetch(input logic [31:0] a, input int flush_cyc, output int n_hold, output int n_words);
    bit cacheable, in_miss, done, pend, complete, exp_hit;
    int words, fill_cyc, lat0, cyc;
    cacheable = (a >= BASE);
    n_hold = 0; n_words = 0; in_miss = 0; done = 0; pend = 0;
    words = 0; fill_cyc = 0; lat0 = 0; cyc = 0;
    ack_addrs.delete();
    cpu_req = 1'b1; cpu_addr = a;
    while (!done) begin
      flush = (cyc == flush_cyc);
      @(negedge clk);
      if (hold) n_hold++;
      if (!in_miss) begin
        exp_hit = model_hit(a);
        check("lookup_hold", hold, !exp_hit);
        if (exp_hit) begin
          m_hits++;
          last_instr = cpu_instr;
          if (flush) model_clear();
          done = 1;
        end else begin
          m_misses++;
          if (flush) model_clear();
          if (cacheable) mvalid[m_index(a)] = 1'b0;
          in_miss = 1; pend = 0; words = 0; fill_cyc = 0; lat0 = lat_sum;
        end
      end else begin
        fill_cyc++;
        if (flush) pend = 1;
        check("miss_req", mem_req, 1'b1);
        complete = 0;
        if (mem_req && mem_ack) begin
          check("mem_addr", mem_addr, cacheable ? (a / LINE_BYTES) * LINE_BYTES + 4 * words : a);
          ack_addrs.push_back(mem_addr);
          words++; n_words++;
          complete = cacheable ? (words == WPL) : 1'b1;
        end
        check("miss_hold", hold, cacheable ? 1'b1 : !complete);
        if (complete) begin
          check("miss_cycles", fill_cyc, lat_sum - lat0);
          if (pend) model_clear();
          else if (cacheable) begin
            mvalid[m_index(a)] = 1'b1;
            mtag[m_index(a)]   = m_tagof(a);
          end
          if (!cacheable) begin
            last_instr = cpu_instr;
            done = 1;
          end
          in_miss = 0;
        end
        if (fill_cyc > 100) begin
          check("miss_timeout", fill_cyc, 0);
          done = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    flush = 1'b0;
    check_stats();
  endtask

  task automatic idle(input int n, input bit rnd_flush);
    cpu_req = 1'b0;
    cpu_addr = $urandom & 32'hFFFF_FFFC;
    repeat (n) begin
      flush = rnd_flush && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check("idle_hold", hold, 1'b0);
      check("idle_req", mem_req, 1'b0);
      if (flush) model_clear();
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cpu_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_hold", hold, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    model_clear();
    m_hits = 0; m_misses = 0;
    check_stats();
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nh, nw, hits0, acks, budget;
    logic [31:0] a;

    lat_fixed = 2; spur_en = 0;
    do_reset();

    // Cold fill of the first cacheable line.
    fetch(32'h0040_0000, -1, nh, nw);
    check("cold_hold_cycles", nh, 9);
    check("cold_words", nw, 4);
    for (int i = 0; i < 4; i++) check("cold_addr", ack_addrs.size() > i ? ack_addrs[i] : 32'hX, 32'h0040_0000 + 4 * i);
    check("cold_instr", last_instr, 32'h0040_0000);

    // Remaining words of the line are hits with no memory traffic.
    hits0 = m_hits;
    for (int i = 1; i < 4; i++) begin
      fetch(32'h0040_0000 + 4 * i, -1, nh, nw);
      check("hit_hold_cycles", nh, 0);
      check("hit_words", nw, 0);
    end
    check("model_hits", m_hits - hits0, 3);

    // Conflict on the same index evicts the line.
    do_reset();
    fetch(32'h0040_0000, -1, nh, nw);
    fetch(32'h0040_0100, -1, nh, nw);
    check("conflict_hold", nh, 9);
    fetch(32'h0040_0000, -1, nh, nw);
    check("refetch_hold", nh, 9);
    check("conflict_misses", m_misses, 3);

    // Uncacheable fetch: one word, no allocation, misses again.
    fetch(32'h0000_0010, -1, nh, nw);
    check("byp_hold", nh, 2);
    check("byp_words", nw, 1);
    check("byp_addr", ack_addrs.size() > 0 ? ack_addrs[0] : 32'hX, 32'h0000_0010);
    fetch(32'h0000_0010, -1, nh, nw);
    check("byp_again_words", nw, 1);
    fetch(32'h003F_FFFC, -1, nh, nw);
    check("below_base_words", nw, 1);

    // Flush on the second cycle of a fill: fill completes but the CPU must refetch.
    fetch(32'h0040_0040, 2, nh, nw);
    check("flush_fill_hold", nh, 18);
    check("flush_fill_words", nw, 8);
    fetch(32'h0040_0040, -1, nh, nw);
    check("after_flush_hit", nh, 0);

    // Reset after the second acked word of a fill.
    cpu_req = 1'b1; cpu_addr = 32'h0040_0080;
    acks = 0; budget = 0;
    while (acks < 2 && budget < 50) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
      budget++;
      @(posedge clk); #1;
    end
    check("pre_reset_acks", acks, 2);
    reset_n = 1'b0;
    #1;
    check("reset_mem_req", mem_req, 1'b0);
    cpu_req = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3, 1'b0);
    fetch(32'h0040_0000, -1, nh, nw);
    check("post_reset_cold", nh, 9);
    fetch(32'h0040_0080, -1, nh, nw);
    check("refill_words", nw, 4);
    check("refill_hold", nh, 9);

    // Randomized traffic: mixed latencies, stray acks, occasional flushes.
    lat_fixed = 0; spur_en = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0)      a = 32'h003F_FF00 + ($urandom_range(0, 63) << 2);
      else if (r == 1) a = ($urandom_range(0, 1) == 0) ? 32'h003F_FFFC : 32'h0040_0000;
      else             a = BASE + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 3) << 4)
                              + ($urandom_range(0, 3) << 2);
      fetch(a, ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 10)) : -1, nh, nw);
      idle($urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
